// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the TDM 1-to-4 demultiplexer
package demux_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] sel_t;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_TDM    = 1'b1;
endpackage

// File: rtl/demux_chan_reg.sv
// demux_chan_reg: one-entry holding register with valid/ready drain
module demux_chan_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic             rd_ready_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    // write wins over drain; a drain clears only the flag, data is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && rd_ready_i) begin
            valid_q <= 1'b0;
        end
    end
    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/demux_14_tdm.sv
// demux_14_tdm: registered 1-to-4 demux, manual or TDM round-robin routing (optional parity check: DEMUX_PARITY_EN)
module demux_14_tdm
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             din_sof,
    input  logic             s1,
    input  logic             s0,
    input  logic             mode,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [NCH-1:0]   y_valid,
    input  logic [NCH-1:0]   y_ready,
    output logic [SEL_W-1:0] slot
`ifdef DEMUX_PARITY_EN
    ,
    input  logic             din_par,
    output logic             par_err
`endif
);
    sel_t             slot_q, slot_d, tgt;
    logic             mode_q, mode_rise, accept, beat_ok;
    logic [NCH-1:0]   wr;
    logic [WIDTH-1:0] y_data [NCH];

`ifdef DEMUX_PARITY_EN
    logic par_err_q;
    assign beat_ok = ~(^din ^ din_par);
    // sticky parity error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_q | (accept & ~beat_ok);
    end
    assign par_err = par_err_q;
`else
    assign beat_ok = 1'b1;
`endif

    assign mode_rise = (mode == MODE_TDM) && (mode_q == MODE_MANUAL);

    // target channel, handshake and the slot counter's next value
    always_comb begin
        tgt       = (mode == MODE_TDM) ? (din_sof ? sel_t'(0) : slot_q) : {s1, s0};
        din_ready = ~y_valid[tgt] | y_ready[tgt];
        accept    = din_valid & din_ready;
        wr        = (accept & beat_ok) ? NCH'(1) << tgt : '0;
        slot_d    = mode_rise ? sel_t'(0)
                  : ((mode == MODE_TDM) && accept) ? sel_t'(tgt + 2'd1)
                  : slot_q;
    end

    // slot counter and mode history for entry-into-TDM realignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            mode_q <= MODE_MANUAL;
        end else begin
            slot_q <= slot_d;
            mode_q <= mode;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_i       (wr[k]),
            .rd_ready_i (y_ready[k]),
            .data_i     (din),
            .data_o     (y_data[k]),
            .valid_o    (y_valid[k])
        );
    end

    assign y0   = y_data[0];
    assign y1   = y_data[1];
    assign y2   = y_data[2];
    assign y3   = y_data[3];
    assign slot = slot_q;
endmodule

// File: tb/tb_demux_14_tdm.sv
// tb_demux_14_tdm: directed self-checking bench for demux_14_tdm (parity cases under DEMUX_PARITY_EN)
module tb_demux_14_tdm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       din_sof = 1'b0;
    logic       s1 = 1'b0;
    logic       s0 = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] y0, y1, y2, y3;
    logic [3:0] y_valid;
    logic [3:0] y_ready = '0;
    logic [1:0] slot;
    int         n_chk = 0;
    int         n_pass = 0;
`ifdef DEMUX_PARITY_EN
    logic       par_flip = 1'b0;
    logic       din_par;
    logic       par_err;
    assign din_par = ^din ^ par_flip;
`endif

    demux_14_tdm #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_sof   (din_sof),
        .s1        (s1),
        .s0        (s0),
        .mode      (mode),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .slot      (slot)
`ifdef DEMUX_PARITY_EN
        ,
        .din_par   (din_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] get_y(int k);
        return (k == 0) ? y0 : (k == 1) ? y1 : (k == 2) ? y2 : y3;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        #12;
        chk("rst_valid", y_valid, 0);
        chk("rst_slot", slot, 0);
        chk("rst_y0", y0, 0);
        chk("rst_rdy", din_ready, 1);
`ifdef DEMUX_PARITY_EN
        chk("rst_perr", par_err, 0);
`endif
        rst_n = 1'b1;
        step;
        // manual routing A,B,C,D to channels 0..3
        mode = 1'b0;
        y_ready = 4'hF;
        din_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            din = 4'(10 + k);
            #1 chk("man_rdy", din_ready, 1);
            step;
            chk("man_y", get_y(k), 10 + k);
            chk("man_v", y_valid, 1 << k);
        end
        din_valid = 1'b0;
        step;
        chk("man_drain", y_valid, 0);
        chk("man_hold", y3, 4'hD);
        // backpressure on channel 2
        y_ready = 4'h0;
        {s1, s0} = 2'b10;
        din = 4'h5;
        din_valid = 1'b1;
        #1 chk("bp_rdy1", din_ready, 1);
        step;
        chk("bp_y2", y2, 5);
        chk("bp_v", y_valid, 4'b0100);
        din = 4'h6;
        #1 chk("bp_rdy2", din_ready, 0);
        step;
        chk("bp_stall", y2, 5);
        y_ready = 4'b0100;
        #1 chk("bp_pass", din_ready, 1);
        step;
        chk("bp_y2b", y2, 6);
        chk("bp_vb", y_valid, 4'b0100);
        din_valid = 1'b0;
        step;
        chk("bp_drain", y_valid, 0);
        // TDM round robin with wrap
        y_ready = 4'hF;
        mode = 1'b1;
        step;
        din_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            din = 4'(i);
            #1 chk("tdm_rdy", din_ready, 1);
            step;
            chk("tdm_slot", slot, i % 4);
            chk("tdm_y", get_y((i - 1) % 4), i);
        end
        // start-of-frame realignment, then sof ignored in manual mode
        din = 4'h9;
        din_sof = 1'b1;
        step;
        chk("sof_y0", y0, 9);
        chk("sof_slot", slot, 1);
        mode = 1'b0;
        {s1, s0} = 2'b11;
        step;
        chk("sofm_y3", y3, 9);
        chk("sofm_slot", slot, 1);
        // entering TDM: beat routes by old slot, slot cleared
        din_sof = 1'b0;
        mode = 1'b1;
        din = 4'hE;
        step;
        chk("rise_y1", y1, 4'hE);
        chk("rise_slot", slot, 0);
        // fill all four channels with slot ending at 3
        din_valid = 1'b0;
        step;
        y_ready = 4'h0;
        mode = 1'b0;
        {s1, s0} = 2'b11;
        din = 4'h8;
        din_valid = 1'b1;
        step;
        mode = 1'b1;
        din_valid = 1'b0;
        step;
        din_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = 4'(i);
            step;
        end
        din_valid = 1'b0;
        chk("full_v", y_valid, 4'hF);
        chk("full_slot", slot, 3);
        chk("full_y3", y3, 8);
        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("ar_v", y_valid, 0);
        chk("ar_slot", slot, 0);
        chk("ar_y2", y2, 0);
        chk("ar_y3", y3, 0);
        mode = 1'b0;
        #1 rst_n = 1'b1;
        step;
`ifdef DEMUX_PARITY_EN
        y_ready = 4'hF;
        {s1, s0} = 2'b00;
        din = 4'h3;
        par_flip = 1'b1;
        din_valid = 1'b1;
        #1 chk("par_rdy", din_ready, 1);
        step;
        chk("par_nowr", y_valid, 0);
        chk("par_err", par_err, 1);
        par_flip = 1'b0;
        din = 4'h5;
        step;
        chk("par_good_y0", y0, 5);
        chk("par_good_v", y_valid, 4'b0001);
        chk("par_sticky", par_err, 1);
        din_valid = 1'b0;
        step;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/demux_14_tdm.md
Name: demux_14_tdm

Overview:
- Registered 1-to-4 demultiplexer. Receiving end of the team's 4:1 select mux: routes one input stream to four output channels.
- Channel chosen by an explicit 2-bit select (manual mode) or an internal round-robin slot counter (TDM mode), with frame realignment.
- Each channel has a one-entry holding register and a valid/ready handshake, so downstream stalls back-pressure the input.

Parameters:
- WIDTH, 1, data width of din and each channel output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input data beat.
- din_valid  input  1  beat present.
- din_ready  output  1  beat accepted this cycle when din_valid && din_ready.
- din_sof  input  1  frame start; TDM mode only; forces beat to channel 0.
- s1  input  1  manual select MSB.
- s0  input  1  manual select LSB.
- mode  input  1  0 = manual select, 1 = TDM round-robin.
- y0, y1, y2, y3  output  WIDTH each  channel data registers.
- y_valid  output  4  bit k = channel k holds data.
- y_ready  input  4  bit k = consumer takes channel k this cycle.
- slot  output  2  current TDM slot counter.

Behaviour:
- Reset (rst_n low, asynchronous): y0..y3 = 0, y_valid = 0, slot = 0, internal mode_q = 0. din_ready is combinational and reads 1 after reset.
- Target channel t:
  - mode=0: t = {s1,s0}.
  - mode=1: t = 0 if din_sof=1, else t = slot.
- din_ready = ~y_valid[t] | y_ready[t]. Pass-through on a full channel whose consumer takes data in the same cycle.
- Accept (din_valid && din_ready):
  - next cycle y_t = din and y_valid[t] = 1.
  - Latency input to output: 1 clock.
- Channel k not written, with y_valid[k] && y_ready[k]: y_valid[k] clears, y_k holds its value (not zeroed).
- Write and drain on the same channel in one cycle: y_valid stays 1, new data loaded.
- y_ready[k] while y_valid[k]=0: ignored.
- Non-target channels are unaffected by accepts. Drains on all four channels are independent and may occur in the same cycle.
- Slot counter, mode=1 only:
  - on accept: slot <= t+1 mod 4 (3 wraps to 0). din_sof accept sets slot to 1.
  - no accept: slot holds.
  - mode=0: slot holds its value.
- mode_q <= mode each cycle.
  - Rising edge of mode (mode=1, mode_q=0): slot <= 0 that cycle, overriding any accept-driven update. The beat accepted in that cycle still routes using the pre-clear slot.
  - Falling edge: no state change.
- din_valid=0: no state change except drains.
- din_sof in mode=0: ignored.
- Reset mid-operation: all held data is discarded and flags cleared immediately. No partial beat survives.

Optional Feature:
- Macro DEMUX_PARITY_EN.
- Defined:
  - adds input din_par (1, even parity over din, so XOR of din and din_par = 0).
  - adds output par_err (1, sticky, reset 0).
  - Accepted beat with bad parity: handshake completes normally and slot advances as for a good beat, but the channel register and y_valid are not written. par_err <= 1 until reset.
- Undefined: ports absent; every accepted beat is written.

Decomposition:
- Package demux_pkg:
  - NCH = 4.
  - SEL_W = 2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - localparams MODE_MANUAL = 0, MODE_TDM = 1.
- Sub-module demux_chan_reg:
  - one-entry register with wr, rd_ready, data, valid.
  - instantiated 4x via generate.
- Top-level contains target selection, slot counter, mode edge detect and the parity check.

Test Plan:
- Manual routing: mode=0, WIDTH=4, all y_ready=1; send 0xA with s1s0=00, 0xB with 01, 0xC with 10, 0xD with 11 on consecutive cycles -> y0..y3 = A,B,C,D, each valid one cycle after its beat; din_ready constantly 1.
- Backpressure: mode=0, y_ready=0000, s1s0=10; send 0x5 then 0x6 -> y2=5 and y_valid=0100; din_ready=0 on the 2nd beat. Then y_ready[2]=1 -> 0x6 accepted same cycle, y2=6 next cycle, y_valid[2] stays 1.
- TDM wrap: mode 0->1, y_ready=1111; send 6 beats 1..6 -> channels 0,1,2,3,0,1 get 1..6; slot sequence after each beat 1,2,3,0,1,2.
- SOF realign: mode=1 with slot=2; beat 0x9 with din_sof=1 -> y0=9, slot=1. Same beat with mode=0 and s1s0=11 -> y3=9, slot unchanged.
- Async reset: with y_valid=1111 and slot=3, pulse rst_n low mid-cycle -> y_valid=0, y0..y3=0, slot=0 immediately, without waiting for a clock edge.
- Parity (DEMUX_PARITY_EN): din=0x3, din_par=1 -> handshake completes, no channel write, par_err=1 and stays high; next good beat writes normally.
